// File: rtl/store_checker_pkg.sv
// Shared types and defaults for the MIPS store-port checker.
// State encoding, store record layout and a saturating counter helper.
package store_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int DEF_DEPTH   = 8;
  localparam int DEF_TIMEOUT = 98;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } store_t;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/store_checker_fifo.sv
// Expected-store queue: DEPTH x 64-bit synchronous FIFO.
// Push and pop never coincide, but both are handled independently anyway.
module store_fifo
  import store_checker_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  store_t din,
  output store_t head,
  output logic   full,
  output logic   empty,
  output logic   one_left
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  store_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    cnt;
  logic           push_ok;
  logic           pop_ok;

  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign one_left = (cnt == ONE_CNT);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign head     = mem[rd_ptr];

  // storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/store_checker.sv
// Store-port monitor: loads expected stores, arms a window,
// matches observed stores in order and reports done/pass.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int STRICT  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exp_valid,
  input  logic [31:0] exp_adr,
  input  logic [31:0] exp_data,
  output logic        exp_ready,
  input  logic        start,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        done,
  output logic        pass,
  output logic [7:0]  store_count,
  output logic [7:0]  stray_count,
  output logic [31:0] last_bad_adr,
  output logic [31:0] last_bad_data
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    store_q, store_d;
  logic [7:0]    stray_q, stray_d;
  logic [31:0]   bad_adr_q, bad_adr_d;
  logic [31:0]   bad_data_q, bad_data_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic          push;
  logic          pop;
  logic          hit;
  logic          drained;
  store_t        din;
  store_t        head;
  logic          full;
  logic          empty;
  logic          one_left;

  assign exp_ready = (state_q == S_IDLE) & ~full;
  assign push      = exp_valid & exp_ready;
  assign din       = '{adr: exp_adr, data: exp_data};

  store_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .din      (din),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .one_left (one_left)
  );

  // next-state and next-output logic for the check window
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    store_d    = store_q;
    stray_d    = stray_q;
    bad_adr_d  = bad_adr_q;
    bad_data_d = bad_data_q;
    done_d     = done_q;
    pass_d     = pass_q;
    pop        = 1'b0;
    hit        = 1'b0;
    drained    = 1'b0;

    // an X/Z compare result falls to the else branch as a mismatch
    if ({dataadr, writedata} == head) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!empty || push) begin
            state_d = S_ARMED;
            timer_d = '0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b0;
          end
        end
      end
      S_ARMED: begin
        timer_d = timer_q + 1'b1;
        if (memwrite) begin
          store_d = sat_inc(store_q);
          if (hit) begin
            pop     = 1'b1;
            drained = one_left;
          end else begin
            stray_d    = sat_inc(stray_q);
            bad_adr_d  = dataadr;
            bad_data_d = writedata;
          end
        end
        // a draining match wins over the timeout in the same cycle
        if (drained) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (STRICT == 0) || (stray_q == 8'd0);
        end else if (timer_q == T_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state, timer, counters and diagnostic capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      store_q    <= '0;
      stray_q    <= '0;
      bad_adr_q  <= '0;
      bad_data_q <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      store_q    <= store_d;
      stray_q    <= stray_d;
      bad_adr_q  <= bad_adr_d;
      bad_data_q <= bad_data_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign done          = done_q;
  assign pass          = pass_q;
  assign store_count   = store_q;
  assign stray_count   = stray_q;
  assign last_bad_adr  = bad_adr_q;
  assign last_bad_data = bad_data_q;

endmodule

// File: tb/tb_store_checker.sv
// Bench for store_checker: directed table, corner sequences and
// randomized windows checked against a queue-based reference model.
module tb_store_checker;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 98;

  logic        clk = 1'b0;
  logic        reset;
  logic        exp_valid;
  logic [31:0] exp_adr;
  logic [31:0] exp_data;
  logic        start;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;

  logic        ready0, ready1;
  logic        done0, done1;
  logic        pass0, pass1;
  logic [7:0]  store0, store1;
  logic [7:0]  stray0, stray1;
  logic [31:0] bada0, bada1;
  logic [31:0] badd0, badd1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STRICT(0)) dut0 (
    .clk(clk), .reset(reset),
    .exp_valid(exp_valid), .exp_adr(exp_adr), .exp_data(exp_data),
    .exp_ready(ready0), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done0), .pass(pass0),
    .store_count(store0), .stray_count(stray0),
    .last_bad_adr(bada0), .last_bad_data(badd0)
  );

  store_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STRICT(1)) dut1 (
    .clk(clk), .reset(reset),
    .exp_valid(exp_valid), .exp_adr(exp_adr), .exp_data(exp_data),
    .exp_ready(ready1), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done1), .pass(pass1),
    .store_count(store1), .stray_count(stray1),
    .last_bad_adr(bada1), .last_bad_data(badd1)
  );

  // reference model: 0 loading, 1 window open, 2 window closed
  logic [63:0] mq[$];
  int          mphase;
  int          mtimer;
  int          mstore;
  int          mstray;
  bit          mp0, mp1;
  logic [31:0] mbad_a, mbad_d;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, req, $time);
    end
  endtask

  task automatic model_step();
    bit timed_out;
    bit emptied;
    if (reset) begin
      mq.delete();
      mphase = 0; mtimer = 0; mstore = 0; mstray = 0;
      mp0 = 0; mp1 = 0; mbad_a = 0; mbad_d = 0;
    end else if (mphase == 0) begin
      if (exp_valid && mq.size() < DEPTH)
        mq.push_back({exp_adr, exp_data});
      if (start) begin
        if (mq.size() > 0) begin
          mphase = 1; mtimer = 0;
        end else begin
          mphase = 2; mp0 = 0; mp1 = 0;
        end
      end
    end else if (mphase == 1) begin
      timed_out = (mtimer == TIMEOUT - 1);
      mtimer++;
      emptied = 0;
      if (memwrite) begin
        if (mstore < 255) mstore++;
        if ((({dataadr, writedata} == mq[0])) === 1'b1) begin
          void'(mq.pop_front());
          emptied = (mq.size() == 0);
        end else begin
          if (mstray < 255) mstray++;
          mbad_a = dataadr; mbad_d = writedata;
        end
      end
      if (emptied) begin
        mphase = 2; mp0 = 1; mp1 = (mstray == 0);
      end else if (timed_out) begin
        mphase = 2; mp0 = 0; mp1 = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic rdy;
    rdy = (mphase == 0) && (mq.size() < DEPTH);
    chk("ready0", 32'(ready0), 32'(rdy));
    chk("ready1", 32'(ready1), 32'(rdy));
    chk("done0", 32'(done0), 32'(mphase == 2));
    chk("done1", 32'(done1), 32'(mphase == 2));
    chk("pass0", 32'(pass0), 32'(mp0));
    chk("pass1", 32'(pass1), 32'(mp1));
    chk("store_count", 32'(store0), 32'(mstore));
    chk("store_count_s", 32'(store1), 32'(mstore));
    chk("stray_count", 32'(stray0), 32'(mstray));
    chk("stray_count_s", 32'(stray1), 32'(mstray));
    chk("last_bad_adr", bada0, mbad_a);
    chk("last_bad_data", badd0, mbad_d);
    chk("last_bad_adr_s", bada1, mbad_a);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic quiet();
    exp_valid = 0; exp_adr = 0; exp_data = 0;
    start = 0; memwrite = 0; dataadr = 0; writedata = 0;
  endtask

  task automatic do_reset();
    quiet(); reset = 1; tick(); reset = 0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    exp_valid = 1; exp_adr = a; exp_data = d; tick(); exp_valid = 0;
  endtask

  task automatic arm();
    start = 1; tick(); start = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1; dataadr = a; writedata = d; tick();
    memwrite = 0; dataadr = 0; writedata = 0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done0 && n < budget) begin
      tick(); n++;
    end
    if (!done0) chk("wait_done_timeout", 32'(done0), 32'd1);
  endtask

  typedef struct {
    logic [31:0] ea, ed;
    bit          bad;
    logic [31:0] ba, bd;
    int          gap;
    bit          xp0, xp1;
    int          xstray, xstore;
  } vec_t;

  vec_t vt[4];

  initial begin
    int n;
    int k;
    int np;
    logic [31:0] a, d;

    reset = 1; quiet();
    mphase = 0; mtimer = 0; mstore = 0; mstray = 0;
    mp0 = 0; mp1 = 0; mbad_a = 0; mbad_d = 0;
    @(negedge clk);
    tick(); tick();
    reset = 0;

    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_pass", 32'(pass0), 32'd0);
    chk("rst_ready", 32'(ready0), 32'd1);
    chk("rst_store", 32'(store0), 32'd0);
    chk("rst_bad_adr", bada0, 32'd0);

    vt[0] = '{32'h14, 32'd21, 0, 32'h0, 32'h0, 9, 1, 1, 0, 1};
    vt[1] = '{32'h54, 32'd7, 1, 32'h50, 32'd7, 0, 1, 0, 1, 2};
    vt[2] = '{32'hdeadbeef, 32'h12345678, 1,
              32'hdeadbeef, 32'h12345679, 3, 1, 0, 1, 2};
    vt[3] = '{32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 1, 0, 1};

    for (int i = 0; i < 4; i++) begin
      do_reset();
      push(vt[i].ea, vt[i].ed);
      arm();
      for (int g = 0; g < vt[i].gap; g++) tick();
      if (vt[i].bad) store(vt[i].ba, vt[i].bd);
      store(vt[i].ea, vt[i].ed);
      chk($sformatf("vec%0d_done", i), 32'(done0), 32'd1);
      chk($sformatf("vec%0d_pass", i), 32'(pass0), 32'(vt[i].xp0));
      chk($sformatf("vec%0d_pass_s", i), 32'(pass1), 32'(vt[i].xp1));
      chk($sformatf("vec%0d_stray", i), 32'(stray0), 32'(vt[i].xstray));
      chk($sformatf("vec%0d_store", i), 32'(store0), 32'(vt[i].xstore));
      if (vt[i].bad) begin
        chk($sformatf("vec%0d_bad_adr", i), bada0, vt[i].ba);
        chk($sformatf("vec%0d_bad_data", i), badd0, vt[i].bd);
      end
      store(vt[i].ea, vt[i].ed);
      chk($sformatf("vec%0d_frozen", i), 32'(store0), 32'(vt[i].xstore));
    end

    // window closes on timeout with no stores
    do_reset();
    push(32'h70f00ff0, 32'd2);
    arm();
    wait_done(TIMEOUT + 10, n);
    chk("timeout_cycles", 32'(n), 32'(TIMEOUT));
    chk("timeout_pass", 32'(pass0), 32'd0);
    chk("timeout_store", 32'(store0), 32'd0);

    // overfill: the extra push is dropped, DEPTH matches drain the queue
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(4 * i), 32'(3 * i));
    chk("full_ready", 32'(ready0), 32'd0);
    push(32'hbad0, 32'hbad1);
    arm();
    for (int i = 0; i < DEPTH; i++) store(32'h100 + 32'(4 * i), 32'(3 * i));
    chk("full_done", 32'(done0), 32'd1);
    chk("full_pass_s", 32'(pass1), 32'd1);
    chk("full_store", 32'(store0), 32'(DEPTH));

    // out-of-order stores: only the head may match
    do_reset();
    push(32'hc, 32'hc);
    push(32'h0, 32'h4);
    arm();
    store(32'h0, 32'h4);
    store(32'hc, 32'hc);
    wait_done(TIMEOUT + 10, n);
    chk("order_pass", 32'(pass0), 32'd0);
    chk("order_stray", 32'(stray0), 32'd1);
    chk("order_bad_adr", bada0, 32'h0);
    chk("order_bad_data", badd0, 32'h4);

    // final match on the very last cycle of the window
    do_reset();
    push(32'h40, 32'h1);
    push(32'h44, 32'h2);
    arm();
    store(32'h40, 32'h1);
    for (int g = 0; g < TIMEOUT - 2; g++) tick();
    store(32'h44, 32'h2);
    chk("edge_done", 32'(done0), 32'd1);
    chk("edge_pass", 32'(pass0), 32'd1);

    // reset in mid-window flushes everything
    do_reset();
    push(32'h2c, 32'd9);
    arm();
    tick(); tick();
    reset = 1; tick(); reset = 0;
    chk("midrst_done", 32'(done0), 32'd0);
    chk("midrst_pass", 32'(pass0), 32'd0);
    chk("midrst_ready", 32'(ready0), 32'd1);
    arm();
    chk("midrst_empty_done", 32'(done0), 32'd1);
    chk("midrst_empty_pass", 32'(pass0), 32'd0);

    // randomized windows
    for (int it = 0; it < 40; it++) begin
      do_reset();
      np = $urandom_range(0, DEPTH + 1);
      for (int i = 0; i < np; i++) begin
        a = 32'($urandom_range(0, 3)) << 2;
        d = 32'($urandom_range(0, 3));
        exp_valid = 1; exp_adr = a; exp_data = d;
        start = (i == np - 1) && ($urandom_range(0, 1) == 1);
        tick();
        exp_valid = 0;
        if ($urandom_range(0, 3) == 0) tick();
      end
      if (mphase == 0) arm();
      k = 0;
      while (mphase == 1 && k < TIMEOUT + 10) begin
        memwrite = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 9) < 6 && mq.size() > 0) begin
          {dataadr, writedata} = mq[0];
        end else begin
          dataadr = 32'($urandom_range(0, 3)) << 2;
          writedata = 32'($urandom_range(0, 3));
        end
        tick();
        k++;
      end
      memwrite = 0;
      chk("rand_closed", 32'(done0), 32'd1);
      memwrite = 1; dataadr = 0; writedata = 0;
      tick();
      memwrite = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
